// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// State encoding and iteration count.
package div_unit_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step (combinational).
// In: rem, dvd_msb, divisor. Out: next_rem, q_bit.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;

  assign shifted  = {rem[WIDTH-2:0], dvd_msb};
  assign diff     = {1'b0, shifted} - {1'b0, divisor};
  // A clear borrow bit means the divisor fit.
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = q_bit ? diff[WIDTH-1:0] : shifted;

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider, one quotient bit per cycle.
// Ports: clock/reset, operands A/B, ctrl_DIV start; result, exception, RDY, busy.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_q, sign_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] abs_a, abs_b;

  // 32-bit negate: |-2^31| stays 0x80000000, read as unsigned.
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    dz_d    = dz_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    if (ctrl_DIV) begin
      dvd_d  = abs_a;
      dvs_d  = abs_b;
      sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      rem_d  = '0;
      cnt_d  = '0;
      dz_d   = (data_operandB == '0);
      state_d = dz_d ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_RUN: begin
          rem_d = step_rem;
          // Quotient bits fill the dividend register as it drains.
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1))
            state_d = S_DONE;
        end
        S_DONE: begin
          rdy_d   = 1'b1;
          exc_d   = dz_q;
          res_d   = dz_q ? '0 : (sign_q ? -dvd_q : dvd_q);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == S_RUN);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit.
// Checks results, latency, busy, abort/restart.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] opa, opb;
  logic        start;
  logic [31:0] result;
  logic        exc, rdy, busy;

  int errors = 0;
  int checks = 0;
  int rdy_seen = 0;
  logic [32:0] sb[$];

  div_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .ctrl_DIV       (start),
    .data_result    (result),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [32:0] got,
                     input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb_;
    sa = a;
    sb_ = b;
    if (b == 0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b0, 32'h8000_0000};
    return {1'b0, 32'(sa / sb_)};
  endfunction

  always @(negedge clock) begin
    if (rdy) begin
      rdy_seen++;
      if (sb.size() == 0) chk("unexp_rdy", 33'd1, 33'd0);
      else chk("result", {exc, result}, sb.pop_front());
    end
  end

  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opa = a;
    opb = b;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input int bcyc);
    int cyc, bc;
    sb.push_back(model(a, b));
    pulse(a, b);
    cyc = 0;
    bc = 0;
    while (!rdy && cyc < 100) begin
      if (busy) bc++;
      @(posedge clock);
      #1 cyc++;
    end
    if (cyc >= 100) chk({tag, "_timeout"}, 33'd0, 33'd1);
    chk({tag, "_lat"}, 33'(cyc), 33'(lat));
    chk({tag, "_busy"}, 33'(bc), 33'(bcyc));
    @(posedge clock);
    #1 chk({tag, "_rdy_drop"}, 33'(rdy), 33'd0);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    start = 1'b0;
    opa = '0;
    opb = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out", {exc, result}, 33'd0);
    chk("rst_rdy_busy", 33'({rdy, busy}), 33'd0);
    reset = 1'b0;

    run_div("t1", 32'd100, 32'd7, 33, 32);
    run_div("t2a", -32'sd100, 32'd7, 33, 32);
    run_div("t2b", 32'd100, -32'sd7, 33, 32);
    run_div("t2c", -32'sd100, -32'sd7, 33, 32);
    run_div("t3", 32'd5, 32'd0, 1, 0);
    run_div("t4a", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32);
    run_div("t4b", 32'h8000_0000, 32'd1, 33, 32);
    run_div("t4c", 32'h7FFF_FFFF, 32'h8000_0000, 33, 32);

    // restart mid-run: first result dropped
    n0 = rdy_seen;
    pulse(32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    run_div("t5", 32'd50, 32'd5, 33, 32);
    chk("t5_one_rdy", 33'(rdy_seen - n0), 33'd1);

    // reset mid-run aborts
    n0 = rdy_seen;
    pulse(32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_rst_out", {exc, result}, 33'd0);
    chk("t6_rst_ctl", 33'({rdy, busy}), 33'd0);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1 chk("t6_no_rdy", 33'(rdy_seen - n0), 33'd0);
    run_div("t6b", 32'd9, 32'd3, 33, 32);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? $urandom_range(1, 300) : $urandom;
      if (i == 5) b = -32'sd13;
      run_div("rnd", a, b, 33, 32);
    end

    repeat (3) @(posedge clock);
    chk("sb_empty", 33'(sb.size()), 33'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
